// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and defaults for the loadable program memory
package pmem_pkg;

  // Controller modes: power-up fill sweep, normal fetch service, byte loading
  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } pmem_state_t;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH          = 2 ** ADDR_W_DEF;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
  localparam logic [DATA_W_DEF-1:0] FILL_DEF = {DATA_W_DEF{1'b1}};

endpackage

// File: rtl/program_memory_loadable_if.sv
// rtl/program_memory_loadable_if.sv - fetch and byte-loader signal bundle
interface program_memory_loadable_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              load_start;
  logic [7:0]        load_byte;
  logic              load_byte_valid;
  logic              load_byte_ready;
  logic              load_done;
  logic              busy;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  // Fetch stage / byte source side
  modport master (
    output fetch_req, fetch_addr, load_start, load_byte, load_byte_valid, load_done,
    input  instr_out, instr_valid, load_byte_ready, busy, load_err, word_count
  );

  // Memory side
  modport slave (
    input  fetch_req, fetch_addr, load_start, load_byte, load_byte_valid, load_done,
    output instr_out, instr_valid, load_byte_ready, busy, load_err, word_count
  );

endinterface

// File: rtl/pmem_sram.sv
// rtl/pmem_sram.sv - single-port synchronous RAM, no reset
module pmem_sram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // One access per enabled cycle: write, or registered read that holds otherwise
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/program_memory_loadable.sv
// rtl/program_memory_loadable.sv - writable instruction store with byte-serial loader
module program_memory_loadable
  import pmem_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
  input logic                     clk,
  input logic                     rst,
  program_memory_loadable_if.slave bus
);

  localparam int NWORDS = 2 ** ADDR_W;
  localparam int BPW    = DATA_W / 8;

  pmem_state_t       state, state_nx;
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W-1:0] wptr;
  logic [7:0]        bcnt;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_nx;
  logic [ADDR_W:0]   wcnt;
  logic              err_q;
  logic              valid_q;
  logic              rd_seen;

  logic              fetch_go;
  logic              byte_acc;
  logic              word_done;
  logic              partial;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  pmem_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Mode register; reset always restarts the fill sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next mode and the single RAM port mux (sweep, load write pointer or fetch address)
  always_comb begin
    state_nx  = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = sweep;
    ram_wdata = FILL;
    fetch_go  = 1'b0;
    byte_acc  = 1'b0;
    word_done = 1'b0;
    asm_nx    = (asm_q << 8) | DATA_W'(bus.load_byte);
    case (state)
      INIT: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        if (sweep == '1) state_nx = RUN;
      end
      RUN: begin
        fetch_go = bus.fetch_req;
        ram_en   = bus.fetch_req;
        ram_addr = bus.fetch_addr;
        if (bus.load_start) state_nx = LOAD;
      end
      LOAD: begin
        ram_addr  = wptr;
        ram_wdata = asm_nx;
        // A restart drops whatever arrives alongside it
        if (!bus.load_start) begin
          byte_acc  = bus.load_byte_valid;
          word_done = byte_acc && (bcnt == 8'(BPW - 1));
          ram_en    = word_done;
          ram_we    = word_done;
          if (bus.load_done) state_nx = RUN;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  // Bytes still held after this cycle's accepted byte, if any
  assign partial = byte_acc ? !word_done : (bcnt != 8'd0);

  // Sweep pointer, word assembler, load counters, error flag and fetch result tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep   <= '0;
      wptr    <= '0;
      bcnt    <= 8'd0;
      asm_q   <= '0;
      wcnt    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      valid_q <= fetch_go;
      if (fetch_go) rd_seen <= 1'b1;
      if (state == INIT) sweep <= sweep + ADDR_W'(1);
      if (bus.load_start && (state != INIT)) begin
        wptr  <= '0;
        bcnt  <= 8'd0;
        asm_q <= '0;
        wcnt  <= '0;
        err_q <= 1'b0;
      end else if (state == LOAD) begin
        if (byte_acc) begin
          if (word_done) begin
            bcnt <= 8'd0;
            wptr <= wptr + ADDR_W'(1);
            if (wcnt == (ADDR_W+1)'(NWORDS)) begin
              err_q <= 1'b1;
            end else begin
              wcnt <= wcnt + (ADDR_W+1)'(1);
            end
          end else begin
            bcnt  <= bcnt + 8'd1;
            asm_q <= asm_nx;
          end
        end
        if (bus.load_done) begin
          bcnt <= 8'd0;
          if (partial) err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.instr_out       = rd_seen ? ram_rdata : FILL;
  assign bus.instr_valid     = valid_q;
  assign bus.busy            = (state != RUN);
  assign bus.load_byte_ready = (state == LOAD);
  assign bus.load_err        = err_q;
  assign bus.word_count      = wcnt;

endmodule

// File: tb/tb_program_memory_loadable.sv
// tb/tb_program_memory_loadable.sv - randomized self-checking bench with behavioural model
module tb_program_memory_loadable;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOAD = 2;
  localparam logic [15:0] FILLV = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  program_memory_loadable_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  program_memory_loadable #(.ADDR_W(5), .DATA_W(16), .FILL(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory as an array, loader bytes as a queue
  int          m_mode;
  int          m_sw;
  int          m_wptr;
  int          m_wc;
  logic        m_err;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_mem [32];
  logic [7:0]  m_q [$];

  task automatic m_clear_session();
    m_q.delete();
    m_wptr = 0;
    m_wc   = 0;
    m_err  = 1'b0;
  endtask

  task automatic m_reset();
    m_mode  = M_INIT;
    m_sw    = 0;
    m_valid = 1'b0;
    m_instr = FILLV;
    m_clear_session();
  endtask

  task automatic m_step();
    case (m_mode)
      M_INIT: begin
        m_valid = 1'b0;
        m_mem[m_sw] = FILLV;
        m_sw++;
        if (m_sw == 32) m_mode = M_RUN;
      end
      M_RUN: begin
        m_valid = bus.fetch_req;
        if (bus.fetch_req) m_instr = m_mem[bus.fetch_addr];
        if (bus.load_start) begin
          m_mode = M_LOAD;
          m_clear_session();
        end
      end
      default: begin
        m_valid = 1'b0;
        if (bus.load_start) begin
          m_clear_session();
        end else begin
          if (bus.load_byte_valid) begin
            m_q.push_back(bus.load_byte);
            if (m_q.size() == 2) begin
              m_mem[m_wptr] = {m_q[0], m_q[1]};
              if (m_wc == 32) m_err = 1'b1;
              else m_wc++;
              m_wptr = (m_wptr + 1) % 32;
              m_q.delete();
            end
          end
          if (bus.load_done) begin
            if (m_q.size() != 0) m_err = 1'b1;
            m_q.delete();
            m_mode = M_RUN;
          end
        end
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = FILLV;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Compare every output against the model on each falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("cmp_instr", 32'(bus.instr_out), 32'(m_instr));
      chk("cmp_busy", 32'(bus.busy), 32'(m_mode != M_RUN));
      chk("cmp_ready", 32'(bus.load_byte_ready), 32'(m_mode == M_LOAD));
      chk("cmp_err", 32'(bus.load_err), 32'(m_err));
      chk("cmp_wc", 32'(bus.word_count), 32'(m_wc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic finish_load();
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) tick();
    bus.load_byte       = b;
    bus.load_byte_valid = 1'b1;
    tick();
    bus.load_byte_valid = 1'b0;
    bus.load_byte       = 8'($urandom);
  endtask

  task automatic fetch_chk(input int a, input logic [15:0] exp, input string name);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 5'(a);
    tick();
    bus.fetch_req  = 1'b0;
    chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk(name, 32'(bus.instr_out), 32'(exp));
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("busy_fall_cycles", 32'(n), 32'd32);
  endtask

  task automatic sweep_all_fill(input string name);
    for (int a = 0; a < 32; a++) fetch_chk(a, FILLV, name);
  endtask

  initial begin
    int nw;
    bus.fetch_req       = 1'b0;
    bus.fetch_addr      = '0;
    bus.load_start      = 1'b0;
    bus.load_byte       = 8'h00;
    bus.load_byte_valid = 1'b0;
    bus.load_done       = 1'b0;

    // Reset state and power-up sweep
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr_out), 32'hFFFF);
    chk("rst_wc", 32'(bus.word_count), 32'd0);
    rst = 1'b0;
    wait_sweep();
    sweep_all_fill("init_fill");

    // Short three-word program
    start_load();
    chk("load_ready", 32'(bus.load_byte_ready), 32'd1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h06, 1); send_byte(8'hA0, 1); send_byte(8'h02, 1);
    finish_load();
    chk("p1_wc", 32'(bus.word_count), 32'd3);
    chk("p1_err", 32'(bus.load_err), 32'd0);
    fetch_chk(0, 16'h0000, "p1_m0");
    fetch_chk(1, 16'h0006, "p1_m1");
    fetch_chk(2, 16'hA002, "p1_m2");
    fetch_chk(3, 16'hFFFF, "p1_m3");

    // 33 words overflow and wrap onto address 0
    start_load();
    for (int i = 0; i < 33; i++) begin
      send_byte(8'(i >> 8), 1);
      send_byte(8'(i), 1);
    end
    finish_load();
    chk("ovf_err", 32'(bus.load_err), 32'd1);
    chk("ovf_wc", 32'(bus.word_count), 32'd32);
    fetch_chk(0, 16'h0020, "ovf_m0");
    fetch_chk(31, 16'h001F, "ovf_m31");

    // Trailing partial word, last byte arrives with load_done
    start_load();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    bus.load_byte = 8'h56; bus.load_byte_valid = 1'b1; bus.load_done = 1'b1;
    tick();
    bus.load_byte_valid = 1'b0; bus.load_done = 1'b0;
    chk("part_wc", 32'(bus.word_count), 32'd1);
    chk("part_err", 32'(bus.load_err), 32'd1);
    chk("part_busy", 32'(bus.busy), 32'd0);
    fetch_chk(0, 16'h1234, "part_m0");
    fetch_chk(1, 16'h0001, "part_m1");

    // Back-to-back fetches with load_start alongside the last one
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 5'd0; tick();
    chk("b2b_v0", 32'(bus.instr_valid), 32'd1);
    chk("b2b_d0", 32'(bus.instr_out), 32'h1234);
    bus.fetch_addr = 5'd1; tick();
    chk("b2b_v1", 32'(bus.instr_valid), 32'd1);
    chk("b2b_d1", 32'(bus.instr_out), 32'h0001);
    bus.fetch_addr = 5'd2; bus.load_start = 1'b1; tick();
    bus.load_start = 1'b0;
    chk("b2b_v2", 32'(bus.instr_valid), 32'd1);
    chk("b2b_d2", 32'(bus.instr_out), 32'h0002);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_load_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.fetch_req = 1'b0;
    finish_load();
    chk("b2b_wc", 32'(bus.word_count), 32'd0);

    // Randomized sessions: random words, gaps, restarts and partials, then random fetches
    for (int s = 0; s < 6; s++) begin
      start_load();
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) begin
        send_byte(8'($urandom), 2);
        send_byte(8'($urandom), 2);
        if ($urandom_range(0, 15) == 0) start_load();
      end
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), 1);
      finish_load();
      for (int f = 0; f < 40; f++) begin
        bus.fetch_req  = ($urandom_range(0, 3) != 0);
        bus.fetch_addr = 5'($urandom_range(0, 12));
        tick();
      end
      bus.fetch_req = 1'b0;
    end

    // Reset in the middle of a load
    start_load();
    for (int w = 0; w < 3; w++) begin
      send_byte(8'hC0, 0);
      send_byte(8'(w), 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_ready", 32'(bus.load_byte_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(bus.instr_out), 32'hFFFF);
    chk("mid_rst_err", 32'(bus.load_err), 32'd0);
    chk("mid_rst_wc", 32'(bus.word_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_sweep();
    sweep_all_fill("post_rst_fill");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_memory_loadable.md
Name: program_memory_loadable

Overview:
- Parametrised, writable successor to the fixed program ROM: a synchronous instruction store that the processor fetches from, with a byte-serial loader so programs can be replaced without resynthesis.
- Sits between the fetch stage (PC -> instruction) and an external byte source such as a UART receiver.
- After reset, a sweep fills every word with FILL. A load session then writes packed words from address 0 upward. In RUN the block serves fetches with 1-cycle latency.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, instruction width; must be a multiple of 8.
- FILL, {DATA_W{1'b1}}, value of unwritten or cleared words (0xFFFF default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch strobe, honoured in RUN only.
- fetch_addr  in  ADDR_W  instruction address.
- instr_out  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr_out valid for this cycle.
- load_start  in  1  pulse: enter LOAD.
- load_byte  in  8  loader data, MSB byte of each word first.
- load_byte_valid  in  1  loader strobe.
- load_byte_ready  out  1  high in LOAD.
- load_done  in  1  pulse: end the load session.
- busy  out  1  high in INIT or LOAD.
- load_err  out  1  sticky error flag; cleared on load_start.
- word_count  out  ADDR_W+1  words written in the current or last session.

Behaviour:
- Reset values (async): state=INIT, sweep pointer=0, instr_out=FILL, instr_valid=0, busy=1, load_byte_ready=0, load_err=0, word_count=0.
- Reset mid-operation (any state) aborts that state and restarts the INIT sweep. Memory contents are not preserved.

FSM states: INIT, RUN, LOAD.
- INIT:
  - Writes FILL to one address per cycle, 0..DEPTH-1, starting on the first clk after rst deasserts.
  - After writing DEPTH-1, goes to RUN. busy is first low DEPTH cycles after reset release.
  - fetch_req, load_start and load bytes are ignored.
- RUN:
  - fetch_req at edge N gives instr_out=mem[fetch_addr] and instr_valid=1 during cycle N+1. With no request, instr_valid=0 and instr_out holds its last value.
  - Back-to-back requests give one result per cycle.
  - load_start=1 moves to LOAD; word_count, load_err, write pointer and byte counter are cleared.
  - A fetch_req in the same cycle as load_start is still served.
- LOAD:
  - load_byte_ready=1 and busy=1; fetch_req is ignored and instr_valid=0.
  - Each accepted byte (load_byte_valid=1) shifts into a word assembler. The first byte lands in bits [DATA_W-1:DATA_W-8].
  - After DATA_W/8 bytes, the word is written to mem[wptr]; wptr increments and word_count increments, saturating at DEPTH.
  - wptr wraps from DEPTH-1 to 0. A write when word_count==DEPTH (i.e. the wrap) sets load_err; the write still occurs.
  - load_done goes to RUN on the next edge:
    - A byte accepted in the same cycle as load_done is taken first, and written if it completes a word.
    - A remaining partial word is discarded and sets load_err.
  - load_start while in LOAD restarts the session: wptr=0, counters and load_err cleared, partial word dropped.
  - Words not rewritten keep their prior contents; there is no implicit clear.
- Memory is a single-port synchronous RAM. The read and write paths are never active in the same cycle.

Decomposition:
- Shared package pmem_pkg:
  - state enum {INIT, RUN, LOAD};
  - localparams DEPTH and BYTES_PER_WORD = DATA_W/8;
  - default FILL constant.
- One sub-module, pmem_sram: parametrised single-port synchronous RAM (we, addr, wdata, rdata) with no reset. The top holds the FSM, assembler and counters and muxes addr between sweep, write and fetch pointers.

Test Plan:
- Reset release, then poll busy -> busy falls exactly 32 cycles after rst deasserts. A fetch of every address 0..31 then returns 0xFFFF with instr_valid one cycle after each request.
- load_start; bytes 0x00,0x00,0x00,0x06,0xA0,0x02; load_done -> word_count=3, load_err=0. Fetches return mem[0]=0x0000, mem[1]=0x0006, mem[2]=0xA002, mem[3]=0xFFFF.
- Load 33 words, word i = i -> load_err=1 and word_count=32; mem[0]=0x0020 (overwritten by the wrap), mem[31]=0x001F.
- Load 0x12,0x34,0x56 then load_done -> mem[0]=0x1234, word_count=1, load_err=1, mem[1] unchanged.
- fetch_req continuously with addr 0,1,2 -> three consecutive valid results. load_start in the same cycle as addr 2 -> the addr 2 result is delivered, followed by instr_valid=0 for the rest of LOAD.
- Assert rst in the middle of a LOAD after 3 words -> all outputs return to reset values immediately. After the 32-cycle sweep, every address reads 0xFFFF.
